// File: rtl/shift_deserializer_if.sv
// ----------------------------------------------------------------------------
// shift_deserializer_if
// Bundles the serial input handshake and the parallel output handshake of
// shift_deserializer.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready are both 1. The source holds its data and valid
// stable until that edge. The sink may raise or lower ready freely.
// in_ready depends combinationally on out_ready.
//
// Signals:
//   is_left_shift  word direction, sampled on the first bit of each word
//   shift_in       serial data bit
//   in_valid       shift_in is valid
//   in_ready       deserializer accepts a bit this cycle
//   data_out       last completed word
//   out_valid      data_out holds an unconsumed word
//   out_ready      consumer takes data_out this cycle
//   bit_count      bits accepted into the current word
//   parity_err     parity result for data_out, qualified by out_valid
//
// Modports:
//   master  bit producer / word consumer side
//   slave   the deserializer
// ----------------------------------------------------------------------------
interface shift_deserializer_if #(
  parameter int SIZE = 8
);
  localparam int CW = $clog2(SIZE + 2);

  logic            is_left_shift;
  logic            shift_in;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] data_out;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   bit_count;
  logic            parity_err;

  modport master (
    output is_left_shift, shift_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, bit_count, parity_err
  );

  modport slave (
    input  is_left_shift, shift_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, bit_count, parity_err
  );
endinterface

// File: rtl/shift_deserializer.sv
// ----------------------------------------------------------------------------
// shift_deserializer
// Serial-to-parallel receiver for the ALU shifter's serial bit stream. One
// bit per cycle is accepted on a valid/ready handshake and assembled into a
// SIZE-bit word, MSB-first (is_left_shift=1) or LSB-first (is_left_shift=0).
// Completed words sit in an output holding register with their own
// valid/ready handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_deserializer_if.slave (serial input + parallel output)
//
// Optional feature macro: SHIFT_DESER_PARITY_EN
//   Defined:   each word is SIZE data bits followed by one even-parity bit;
//              parity_err = XOR of data bits and parity bit.
//   Undefined: each word is SIZE bits; parity_err is tied to 0.
// ----------------------------------------------------------------------------
module shift_deserializer #(
  parameter int SIZE = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  shift_deserializer_if.slave  bus
);
  localparam int CW = $clog2(SIZE + 2);
`ifdef SHIFT_DESER_PARITY_EN
  localparam int LAST = SIZE;
`else
  localparam int LAST = SIZE - 1;
`endif
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [SIZE-1:0] sr;
  logic [SIZE-1:0] sr_next;
  logic [SIZE-1:0] data_q;
  logic [CW-1:0]   cnt_q;
  logic            dir_q;
  logic            dir_eff;
  logic            ov_q;
  logic            at_last;
  logic            in_ready_c;
  logic            accept;

  always_comb begin
    at_last    = (cnt_q == LAST_C);
    // The first bit of a word uses the live direction input; later bits use
    // the latched copy so mid-word changes are ignored.
    dir_eff    = (cnt_q == '0) ? bus.is_left_shift : dir_q;
    sr_next    = dir_eff ? {sr[SIZE-2:0], bus.shift_in}
                         : {bus.shift_in, sr[SIZE-1:1]};
    // Only the word-completing bit can be blocked, and only while the
    // holding register is full and not being drained this cycle.
    in_ready_c = !at_last || !ov_q || bus.out_ready;
    accept     = bus.in_valid && in_ready_c;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.data_out  = data_q;
  assign bus.out_valid = ov_q;
  assign bus.bit_count = cnt_q;

`ifdef SHIFT_DESER_PARITY_EN
  logic perr_q;
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      data_q <= '0;
      ov_q   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        if (cnt_q == '0) dir_q <= bus.is_left_shift;
        if (at_last) begin
          cnt_q <= '0;
`ifdef SHIFT_DESER_PARITY_EN
          // Final bit is the parity bit: the data word is already in sr.
          data_q <= sr;
          perr_q <= (^sr) ^ bus.shift_in;
`else
          data_q <= sr_next;
          sr     <= sr_next;
`endif
        end else begin
          sr    <= sr_next;
          cnt_q <= cnt_q + CW'(1);
        end
      end

      // A completing word wins over a consume in the same cycle, so the
      // replaced word is presented without a gap.
      if (accept && at_last) ov_q <= 1'b1;
      else if (ov_q && bus.out_ready) ov_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;
  localparam int SIZE = 8;
  localparam int CW   = $clog2(SIZE + 2);
`ifdef SHIFT_DESER_PARITY_EN
  localparam int NB = SIZE + 1;
`else
  localparam int NB = SIZE;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_deserializer_if #(.SIZE(SIZE)) bus();

  shift_deserializer #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_err  = 0;
  int stalls = 0;
  logic [SIZE:0] exp_q[$];   // {parity_err, data_out}
  logic [SIZE:0] mon_exp;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // seq[SIZE-1] is the first bit on the wire.
  function automatic logic [SIZE-1:0] expect_word(input logic [SIZE-1:0] seq,
                                                  input logic dir);
    logic [SIZE-1:0] r;
    if (dir) return seq;
    for (int i = 0; i < SIZE; i++) r[i] = seq[SIZE-1-i];
    return r;
  endfunction

  function automatic logic word_bit(input logic [SIZE-1:0] seq, input logic par,
                                    input int i);
    if (i < SIZE) return seq[SIZE-1-i];
    return par;
  endfunction

  function automatic logic exp_perr(input logic [SIZE-1:0] seq, input logic par);
`ifdef SHIFT_DESER_PARITY_EN
    return (^seq) ^ par;
`else
    return 1'b0 & (^seq) & par;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drives one bit and returns 1 time unit after the edge that accepted it.
  task automatic send_bit(input logic b, input logic dir);
    int waited = 0;
    bus.in_valid      = 1'b1;
    bus.shift_in      = b;
    bus.is_left_shift = dir;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      stalls++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // toggle_at >= 0: bits after index toggle_at are driven with inverted dir.
  task automatic send_word(input logic [SIZE-1:0] seq, input logic dir,
                           input logic par, input int toggle_at);
    logic d;
    for (int i = 0; i < NB; i++) begin
      d = (toggle_at >= 0 && i > toggle_at) ? ~dir : dir;
      if (i == NB - 1) exp_q.push_back({exp_perr(seq, par), expect_word(seq, dir)});
      send_bit(word_bit(seq, par, i), d);
    end
    bus.in_valid = 1'b0;
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_word", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("word", 32'({bus.parity_err, bus.data_out}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [SIZE-1:0] w1, w2, w3, w4;
  logic            d4;

  initial begin
    bus.in_valid      = 1'b0;
    bus.shift_in      = 1'b0;
    bus.is_left_shift = 1'b0;
    bus.out_ready     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check_eq("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check_eq("rst_data_out",   32'(bus.data_out),   32'd0);
    check_eq("rst_bit_count",  32'(bus.bit_count),  32'd0);
    check_eq("rst_parity_err", 32'(bus.parity_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // MSB-first 1,0,1,1,0,0,1,0 -> B2, out_valid for one cycle
    sync();
    bus.out_ready = 1'b1;
    send_word(8'hB2, 1'b1, ^8'hB2, -1);
    @(negedge clk);
    check_eq("msb_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("msb_data_out",  32'(bus.data_out),  32'hB2);
    check_eq("msb_bit_count", 32'(bus.bit_count), 32'd0);
    @(negedge clk);
    check_eq("msb_valid_one_cycle", 32'(bus.out_valid), 32'd0);

    // LSB-first same bits -> 4D
    sync();
    send_word(8'hB2, 1'b0, ^8'hB2, -1);
    @(negedge clk);
    check_eq("lsb_data_out", 32'(bus.data_out), 32'h4D);

    // Direction latched on the first bit; toggled after bit 3
    sync();
    send_word(8'hB2, 1'b1, ^8'hB2, 3);
    @(negedge clk);
    check_eq("dir_latch_data_out", 32'(bus.data_out), 32'hB2);

    // Sustained throughput, random words and directions
    sync();
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      w1 = SIZE'($urandom_range(0, (1 << SIZE) - 1));
      send_word(w1, 1'($urandom_range(0, 1)), ^w1, -1);
    end
    check_eq("no_stalls", 32'(stalls), 32'd0);
    repeat (3) @(negedge clk);

    // Backpressure: word 1 held, word 2 stalls on its final bit
    sync();
    bus.out_ready = 1'b0;
    w1 = SIZE'($urandom_range(0, (1 << SIZE) - 1));
    w2 = SIZE'($urandom_range(0, (1 << SIZE) - 1));
    send_word(w1, 1'b1, ^w1, -1);
    for (int i = 0; i < NB - 1; i++) send_bit(word_bit(w2, ^w2, i), 1'b0);
    exp_q.push_back({exp_perr(w2, ^w2), expect_word(w2, 1'b0)});
    bus.shift_in = word_bit(w2, ^w2, NB - 1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_eq("bp_in_ready",  32'(bus.in_ready),  32'd0);
    check_eq("bp_bit_count", 32'(bus.bit_count), 32'(NB - 1));
    check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_held_word", 32'(bus.data_out),  32'(w1));
    repeat (2) @(negedge clk);
    check_eq("bp_still_stalled", 32'(bus.in_ready),  32'd0);
    check_eq("bp_count_held",    32'(bus.bit_count), 32'(NB - 1));
    sync();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_comb", 32'(bus.in_ready), 32'd1);
    sync();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check_eq("bp_word2_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_word2_data",  32'(bus.data_out),  32'(expect_word(w2, 1'b0)));
    check_eq("bp_word2_count", 32'(bus.bit_count), 32'd0);
    sync();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("bp_drained", 32'(bus.out_valid), 32'd0);

    // Reset mid-word with a pending output word
    sync();
    bus.out_ready = 1'b0;
    w3 = SIZE'($urandom_range(0, (1 << SIZE) - 1));
    send_word(w3, 1'b1, ^w3, -1);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("mid_rst_out_valid",  32'(bus.out_valid),  32'd0);
    check_eq("mid_rst_data_out",   32'(bus.data_out),   32'd0);
    check_eq("mid_rst_bit_count",  32'(bus.bit_count),  32'd0);
    check_eq("mid_rst_parity_err", 32'(bus.parity_err), 32'd0);
    check_eq("mid_rst_in_ready",   32'(bus.in_ready),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    bus.out_ready = 1'b1;
    w4 = SIZE'($urandom_range(0, (1 << SIZE) - 1));
    d4 = 1'($urandom_range(0, 1));
    send_word(w4, d4, ^w4, -1);
    @(negedge clk);
    check_eq("post_rst_word", 32'(bus.data_out), 32'(expect_word(w4, d4)));

`ifdef SHIFT_DESER_PARITY_EN
    // Parity bit good (0) and bad (1) after B2 MSB-first
    for (int p = 0; p < 2; p++) begin
      sync();
      for (int i = 0; i < SIZE; i++) send_bit(word_bit(8'hB2, 1'b0, i), 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("par_count_before", 32'(bus.bit_count), 32'(SIZE));
      check_eq("par_valid_before", 32'(bus.out_valid), 32'd0);
      sync();
      exp_q.push_back({1'(p), 8'hB2});
      send_bit(1'(p), 1'b1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("par_valid_after", 32'(bus.out_valid),  32'd1);
      check_eq("par_data",        32'(bus.data_out),   32'hB2);
      check_eq("par_err",         32'(bus.parity_err), 32'(p));
    end
`endif

    repeat (4) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
